// File: rtl/led_pwm_pkg.sv
// Purpose : shared register map, CTRL field positions and reset values for led_pwm_driver.
// Latency : n/a (constants only).
// Backpr. : n/a.
package led_pwm_pkg;

    // Control-slave register map (2-bit word address)
    typedef enum logic [1:0] {
        ADDR_CTRL       = 2'd0,
        ADDR_BLINK_MASK = 2'd1,
        ADDR_BLINK_HALF = 2'd2,
        ADDR_STATUS     = 2'd3
    } reg_addr_e;

    // CTRL field positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_BRI_LSB = 4;
    localparam int CTRL_BRI_MSB = 7;

    // Register reset values
    localparam logic        RST_EN         = 1'b1;
    localparam logic [3:0]  RST_BRI        = 4'hF;
    localparam logic [15:0] RST_BLINK_HALF = 16'd0;

endpackage

// File: rtl/led_pwm_timebase.sv
// Purpose : prescaler + PWM counter; produces the per-tick strobe and the frame boundary strobe.
// Latency : tick/frame are combinational from the counters; counters advance every clk.
// Backpr. : none, free-running.
// Ports   : clk, reset (sync, active-high) in; pwm_cnt, tick, frame out.
module led_pwm_timebase #(
    parameter int PWM_BITS = 4,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                tick,
    output logic                frame
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;

    assign tick  = (presc == PW'(PRESCALE - 1));
    // Last tick of the frame: the counter is about to wrap to zero
    assign frame = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick) begin
                presc   <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                presc   <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Purpose : drives board LEDs from the PIO pattern with global PWM brightness and per-LED blink.
// Latency : led_out registered, 1 clk after its inputs; pattern/brightness take effect at the next frame boundary.
// Backpr. : none; Avalon-MM slave has zero wait states, readdata is a combinational mux.
// Ports   : clk, reset (sync, active-high), pattern_in[WIDTH], address/chipselect/write_n/writedata
//           (control slave) in; readdata[32], led_out[WIDTH], frame_start out.
// Config  : define LED_PWM_BLINK_EN to build the blink counter and the BLINK_MASK/BLINK_HALF
//           registers; without it those addresses read 0 and blink_phase is constant 1.
module led_pwm_driver #(
    parameter int WIDTH    = 14,
    parameter int PWM_BITS = 4,
    parameter int PRESCALE = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] led_out,
    output logic             frame_start
);
    import led_pwm_pkg::*;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                frame;

    led_pwm_timebase #(
        .PWM_BITS(PWM_BITS),
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .pwm_cnt(pwm_cnt),
        .tick   (tick),
        .frame  (frame)
    );

    logic wr;
    assign wr = chipselect && !write_n;

    // ---------------- CTRL register (not shadowed: enable acts immediately)
    logic       ctrl_en;
    logic [3:0] ctrl_bri;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en  <= RST_EN;
            ctrl_bri <= RST_BRI;
        end else if (wr && address == ADDR_CTRL) begin
            ctrl_en  <= writedata[CTRL_EN_BIT];
            ctrl_bri <= writedata[CTRL_BRI_MSB:CTRL_BRI_LSB];
        end
    end

    // Brightness is 4 bits; align it to the PWM counter width (left-aligned)
    logic [PWM_BITS-1:0] bri_scaled;
    generate
        if (PWM_BITS == 4) begin : g_bri_eq
            assign bri_scaled = ctrl_bri;
        end else if (PWM_BITS > 4) begin : g_bri_wide
            assign bri_scaled = {ctrl_bri, {(PWM_BITS-4){1'b0}}};
        end else begin : g_bri_narrow
            assign bri_scaled = ctrl_bri[3 -: PWM_BITS];
        end
    endgenerate

    // ---------------- Frame-boundary shadows
    // Non-blocking update means a write landing on the boundary cycle is seen one frame later.
    logic [WIDTH-1:0]    shadow_pat;
    logic [PWM_BITS-1:0] shadow_bri;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_pat <= '0;
            shadow_bri <= '0;
        end else if (frame) begin
            shadow_pat <= pattern_in;
            shadow_bri <= bri_scaled;
        end
    end

    // ---------------- Blink
    logic [WIDTH-1:0] blink_mask;
    logic [15:0]      blink_half;
    logic             blink_phase;

`ifdef LED_PWM_BLINK_EN
    logic [15:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask  <= '0;
            blink_half  <= RST_BLINK_HALF;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (wr && address == ADDR_BLINK_MASK)
                blink_mask <= writedata[WIDTH-1:0];
            // Reprogramming the period restarts the blink in the visible phase
            if (wr && address == ADDR_BLINK_HALF) begin
                blink_half  <= writedata[15:0];
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (frame) begin
                if (blink_half == '0) begin
                    blink_cnt   <= '0;
                    blink_phase <= 1'b1;
                end else if (blink_cnt == blink_half - 16'd1) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt   <= blink_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign blink_mask  = '0;
    assign blink_half  = '0;
    assign blink_phase = 1'b1;
`endif

    // ---------------- Output stage
    logic on;
    assign on = (pwm_cnt < shadow_bri) || (shadow_bri == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            led_out     <= {WIDTH{ctrl_en & on}} & shadow_pat & (~blink_mask | {WIDTH{blink_phase}});
            frame_start <= frame;
        end
    end

    // ---------------- Read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN_BIT]                 = ctrl_en;
                readdata[CTRL_BRI_MSB:CTRL_BRI_LSB]   = ctrl_bri;
            end
            ADDR_BLINK_MASK: readdata[WIDTH-1:0] = blink_mask;
            ADDR_BLINK_HALF: readdata[15:0]      = blink_half;
            ADDR_STATUS: begin
                readdata[0]          = blink_phase;
                readdata[WIDTH+15:16] = shadow_pat;
            end
            default: ;
        endcase
    end

    // Bits of the write bus and the tick strobe that no register consumes
    logic unused_bits;
    assign unused_bits = ^{writedata, tick};

endmodule

// File: tb/tb_led_pwm_driver.sv
// Purpose : self-checking bench for led_pwm_driver with default parameters (800-cycle frame).
// Latency : expected LED patterns are queued when stimulus is applied and popped one cycle after frame_start.
// Backpr. : n/a.
module tb_led_pwm_driver;
    localparam int WIDTH = 14;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] pattern_in = '0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] led_out;
    logic             frame_start;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_v;
    logic [31:0]      rd;

    led_pwm_driver dut (
        .clk        (clk),
        .reset      (reset),
        .pattern_in (pattern_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_out    (led_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Advance until frame_start is sampled high; an expired budget is a failure
    task automatic wait_fs(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < budget);
        if (frame_start !== 1'b1) begin
            checks++; errors++;
            $display("FAIL frame_start_timeout: not seen within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pattern_in = 14'h2AAA;
        step(3);
        checks++; if (led_out !== '0) begin errors++; $display("FAIL rst_led: got %h want 0", led_out); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b want 0", frame_start); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h0000_00F1) begin errors++; $display("FAIL rst_ctrl: got %h want 000000f1", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h want 0", rd); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_half: got %h want 0", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_status: got %h want 1", rd); end
    endtask

    task automatic test_first_frame;
        int dark_bad = 0;
        int fs_at = -1;
        int steady_bad = 0;
        @(negedge clk);
        reset = 1'b0;             // this sample point is cycle 0
        exp_q.push_back(14'h2AAA);
        for (int c = 1; c <= 800; c++) begin
            step(1);
            if (led_out !== '0) dark_bad++;
            if (frame_start === 1'b1 && fs_at < 0) fs_at = c;
        end
        checks++; if (dark_bad != 0) begin errors++; $display("FAIL first_dark: %0d lit cycles, want 0", dark_bad); end
        checks++; if (fs_at != 800) begin errors++; $display("FAIL first_fs_cycle: got %0d want 800", fs_at); end
        step(1);
        exp_v = exp_q.pop_front();
        checks++; if (led_out !== exp_v) begin errors++; $display("FAIL first_pattern: got %h want %h", led_out, exp_v); end
        for (int c = 802; c <= 1600; c++) begin
            step(1);
            if (led_out !== 14'h2AAA) steady_bad++;
        end
        checks++; if (steady_bad != 0) begin errors++; $display("FAIL full_bright_steady: %0d bad cycles, want 0", steady_bad); end
    endtask

    task automatic test_brightness;
        int highs = 0;
        int other = 0;
        logic [WIDTH-1:0] first_s, off_s;
        bus_write(2'd0, 32'h41);
        wait_fs(2000);
        for (int k = 1; k <= 800; k++) begin
            step(1);
            if (k == 1) first_s = led_out;
            if (k == 201) off_s = led_out;
            if (led_out === 14'h2AAA) highs++;
            else if (led_out !== '0) other++;
        end
        checks++; if (first_s !== 14'h2AAA) begin errors++; $display("FAIL bri4_first: got %h want 2aaa", first_s); end
        checks++; if (highs != 200) begin errors++; $display("FAIL bri4_high_cycles: got %0d want 200", highs); end
        checks++; if (off_s !== '0) begin errors++; $display("FAIL bri4_off_at_201: got %h want 0", off_s); end
        checks++; if (other != 0) begin errors++; $display("FAIL bri4_glitch: %0d cycles, want 0", other); end
    endtask

    task automatic test_pattern_change;
        int early = 0;
        int n = 0;
        pattern_in = 14'h0001;
        bus_write(2'd0, 32'hF1);
        exp_q.push_back(14'h0001);
        wait_fs(2000);
        step(1);
        exp_v = exp_q.pop_front();
        checks++; if (led_out !== exp_v) begin errors++; $display("FAIL pat1: got %h want %h", led_out, exp_v); end
        step(300);
        pattern_in = 14'h0002;
        exp_q.push_back(14'h0002);
        do begin
            step(1);
            n++;
            if (led_out !== 14'h0001) early++;
        end while (frame_start !== 1'b1 && n < 1000);
        checks++; if (early != 0 || frame_start !== 1'b1) begin
            errors++; $display("FAIL pat_hold: %0d changed cycles fs=%b, want 0 and 1", early, frame_start);
        end
        step(1);
        exp_v = exp_q.pop_front();
        checks++; if (led_out !== exp_v) begin errors++; $display("FAIL pat2: got %h want %h", led_out, exp_v); end
    endtask

    task automatic test_disable;
        bus_write(2'd0, 32'hF0);
        step(1);
        checks++; if (led_out !== '0) begin errors++; $display("FAIL dis_led: got %h want 0", led_out); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'hF0) begin errors++; $display("FAIL dis_ctrl: got %h want f0", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd[29:16] !== 14'h0002) begin errors++; $display("FAIL dis_status_pat: got %h want 0002", rd[29:16]); end
        @(negedge clk);
        bus_write(2'd0, 32'hF1);
    endtask

`ifdef LED_PWM_BLINK_EN
    task automatic test_blink;
        int n = 0;
        int bit1_bad = 0;
        pattern_in = 14'h0003;
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h2);
        exp_q.push_back(14'h0003);
        wait_fs(2000);
        bus_read(2'd3, rd);
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL blink_phase_b1: got %b want 1", rd[0]); end
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++; if (led_out !== exp_v) begin errors++; $display("FAIL blink_on: got %h want %h", led_out, exp_v); end
        wait_fs(2000);
        bus_read(2'd3, rd);
        checks++; if (rd[0] !== 1'b0) begin errors++; $display("FAIL blink_phase_b2: got %b want 0", rd[0]); end
        @(negedge clk);
        checks++; if (led_out !== 14'h0002) begin errors++; $display("FAIL blink_off: got %h want 0002", led_out); end
        while (led_out[0] !== 1'b1 && n < 2000) begin
            step(1);
            n++;
            if (led_out[1] !== 1'b1) bit1_bad++;
        end
        checks++; if (n != 1600) begin errors++; $display("FAIL blink_period: got %0d want 1600", n); end
        checks++; if (bit1_bad != 0) begin errors++; $display("FAIL blink_bit1_steady: %0d bad, want 0", bit1_bad); end
        bus_read(2'd3, rd);
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL blink_phase_on: got %b want 1", rd[0]); end
        @(negedge clk);
        wait_fs(2000);
        wait_fs(2000);
        step(1);
        checks++; if (led_out !== 14'h0002) begin errors++; $display("FAIL blink_off2: got %h want 0002", led_out); end
        step(100);
    endtask
`else
    task automatic test_blink;
        bus_write(2'd1, 32'h3FFF);
        bus_write(2'd2, 32'h5);
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL noblink_mask: got %h want 0", rd); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL noblink_half: got %h want 0", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL noblink_phase: got %b want 1", rd[0]); end
        @(negedge clk);
        step(50);
    endtask
`endif

    task automatic test_reset_mid;
        reset = 1'b1;
        step(1);
        checks++; if (led_out !== '0) begin errors++; $display("FAIL mid_rst_led: got %h want 0", led_out); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mid_rst_status: got %h want 1", rd); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'hF1) begin errors++; $display("FAIL mid_rst_ctrl: got %h want f1", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_mask: got %h want 0", rd); end
        @(negedge clk);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_brightness();
        test_pattern_change();
        test_disable();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
